// File: rtl/b_bus_pkg.sv
// b_bus_pkg: shared constants for the B-bus register file.
//   SEL_ZERO / SEL_EXT / SEL_REG_BASE : read-select codes
//   reg_sel_code(idx)                 : select code that reads register idx
package b_bus_pkg;

    localparam int SEL_ZERO     = 0;
    localparam int SEL_EXT      = 1;
    localparam int SEL_REG_BASE = 2;

    function automatic int reg_sel_code(input int idx);
        return SEL_REG_BASE + idx;
    endfunction

endpackage

// File: rtl/b_bus_reg.sv
// b_bus_reg: one DATA_W data register. A write takes priority over an
// increment, and the increment wraps modulo 2^DATA_W.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   wr_en      : load d
//   inc_en     : add one (ignored while wr_en is set)
//   d          : write data
//   q          : current register value
module b_bus_reg
    import b_bus_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              inc_en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (wr_en) begin
            r_q <= d;
        end else if (inc_en) begin
            r_q <= r_q + DATA_W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/b_bus_regfile.sv
// b_bus_regfile: NREGS data registers written from the C bus, with
// per-register auto-increment, and a registered B-bus source selector.
// Optional feature macro: B_BUS_BYPASS_EN -- when defined, a read of a
// register that is being written/incremented in the same cycle returns the
// post-update value; otherwise the pre-update value is returned.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   rd_req     : read request
//   rd_sel     : 0 zero, 1 ext_in, 2..NREGS+1 R0..R(NREGS-1), else zero + error
//   ext_in     : external byte, zero-extended on read
//   c_bus      : write data
//   wr_en      : per-register write mask
//   inc_en     : per-register increment enable
//   b_bus      : registered B-bus value (holds when no request)
//   b_valid    : b_bus was loaded by the previous cycle's request
//   sel_err    : previous request used an out-of-range select
module b_bus_regfile
    import b_bus_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int EXT_W  = 8,
    parameter int SEL_W  = $clog2(NREGS + 2)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [SEL_W-1:0]  rd_sel,
    input  logic [EXT_W-1:0]  ext_in,
    input  logic [DATA_W-1:0] c_bus,
    input  logic [NREGS-1:0]  wr_en,
    input  logic [NREGS-1:0]  inc_en,
    output logic [DATA_W-1:0] b_bus,
    output logic              b_valid,
    output logic              sel_err
);

    logic [DATA_W-1:0] w_q  [NREGS];
    logic [DATA_W-1:0] w_rd [NREGS];
    logic [DATA_W-1:0] w_src;
    logic              w_oor;

    logic [DATA_W-1:0] r_b_bus;
    logic              r_b_valid;
    logic              r_sel_err;

    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        b_bus_reg #(
            .DATA_W (DATA_W)
        ) u_reg (
            .clk    (clk),
            .reset  (reset),
            .wr_en  (wr_en[g]),
            .inc_en (inc_en[g]),
            .d      (c_bus),
            .q      (w_q[g])
        );

`ifdef B_BUS_BYPASS_EN
        // Forward the value the register will hold after this edge.
        assign w_rd[g] = wr_en[g]  ? c_bus :
                         inc_en[g] ? w_q[g] + DATA_W'(1) :
                                     w_q[g];
`else
        assign w_rd[g] = w_q[g];
`endif
    end

    always_comb begin
        w_src = '0;
        w_oor = (32'(rd_sel) > 32'(NREGS + 1));
        if (32'(rd_sel) == 32'(SEL_EXT)) begin
            w_src = DATA_W'(ext_in);
        end
        for (int k = 0; k < NREGS; k++) begin
            if (32'(rd_sel) == 32'(reg_sel_code(k))) begin
                w_src = w_rd[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_b_bus   <= '0;
            r_b_valid <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            r_b_valid <= rd_req;
            r_sel_err <= rd_req & w_oor;
            if (rd_req) begin
                r_b_bus <= w_src;
            end
        end
    end

    assign b_bus   = r_b_bus;
    assign b_valid = r_b_valid;
    assign sel_err = r_sel_err;

endmodule

// File: tb/tb_b_bus_regfile.sv
module tb_b_bus_regfile;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int EXT_W  = 8;
    localparam int SEL_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              rd_req;
    logic [SEL_W-1:0]  rd_sel;
    logic [EXT_W-1:0]  ext_in;
    logic [DATA_W-1:0] c_bus;
    logic [NREGS-1:0]  wr_en;
    logic [NREGS-1:0]  inc_en;
    logic [DATA_W-1:0] b_bus;
    logic              b_valid;
    logic              sel_err;

    b_bus_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .EXT_W  (EXT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rd_req  (rd_req),
        .rd_sel  (rd_sel),
        .ext_in  (ext_in),
        .c_bus   (c_bus),
        .wr_en   (wr_en),
        .inc_en  (inc_en),
        .b_bus   (b_bus),
        .b_valid (b_valid),
        .sel_err (sel_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              v;
        logic [DATA_W-1:0] b;
        logic              e;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: register contents and the B-bus hold value.
    logic [DATA_W-1:0] m_r [NREGS];
    logic [DATA_W-1:0] m_b;

    // Drive one cycle of inputs, predict the response to the coming edge.
    task automatic cyc(input logic rst, input logic rq, input logic [SEL_W-1:0] sel,
                       input logic [EXT_W-1:0] ext, input logic [DATA_W-1:0] c,
                       input logic [NREGS-1:0] we, input logic [NREGS-1:0] ie);
        exp_t e;
        logic [DATA_W-1:0] nr  [NREGS];
        logic [DATA_W-1:0] src [NREGS];
        int s;
        reset  = rst;
        rd_req = rq;
        rd_sel = sel;
        ext_in = ext;
        c_bus  = c;
        wr_en  = we;
        inc_en = ie;
        s = int'(sel);
        for (int k = 0; k < NREGS; k++) begin
            if (we[k])      nr[k] = c;
            else if (ie[k]) nr[k] = DATA_W'((int'(m_r[k]) + 1) % 65536);
            else            nr[k] = m_r[k];
        end
`ifdef B_BUS_BYPASS_EN
        src = nr;
`else
        src = m_r;
`endif
        if (rst) begin
            for (int k = 0; k < NREGS; k++) m_r[k] = '0;
            m_b = '0;
            e.v = 1'b0;
            e.e = 1'b0;
        end else begin
            if (rq) begin
                if (s == 1)                      m_b = DATA_W'(ext);
                else if (s >= 2 && s <= NREGS+1) m_b = src[s-2];
                else                             m_b = '0;
                e.v = 1'b1;
                e.e = (s > NREGS + 1);
            end else begin
                e.v = 1'b0;
                e.e = 1'b0;
            end
            m_r = nr;
        end
        e.b = m_b;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the DUT outputs after each edge against the
    // prediction queued for that edge.
    exp_t mon_e;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            checks++;
            if (b_valid !== mon_e.v) begin
                errors++;
                $display("FAIL b_valid: got %b expected %b at %0t", b_valid, mon_e.v, $time);
            end
            checks++;
            if (b_bus !== mon_e.b) begin
                errors++;
                $display("FAIL b_bus: got %h expected %h at %0t", b_bus, mon_e.b, $time);
            end
            checks++;
            if (sel_err !== mon_e.e) begin
                errors++;
                $display("FAIL sel_err: got %b expected %b at %0t", sel_err, mon_e.e, $time);
            end
        end
    end

    initial begin
        int drain;
        for (int k = 0; k < NREGS; k++) m_r[k] = '0;
        m_b = '0;

        // Reset with garbage on all inputs.
        repeat (2) cyc(1'b1, 1'b1, SEL_W'($urandom), EXT_W'($urandom), DATA_W'($urandom),
                       NREGS'($urandom), NREGS'($urandom));
        for (int k = 0; k < NREGS; k++) cyc(1'b0, 1'b1, SEL_W'(k + 2), 8'h00, 16'h0, 8'h00, 8'h00);

        // Write R2 then read it.
        cyc(1'b0, 1'b0, 4'd0, 8'h00, 16'hA5C3, 8'h04, 8'h00);
        cyc(1'b0, 1'b1, 4'd4, 8'h00, 16'h0000, 8'h00, 8'h00);
        cyc(1'b0, 1'b0, 4'd0, 8'h00, 16'h0000, 8'h00, 8'h00);

        // External byte, zero source, out-of-range select.
        cyc(1'b0, 1'b1, 4'd1,  8'hF0, 16'h0, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 4'd0,  8'hF0, 16'h0, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 4'd15, 8'hF0, 16'h0, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 4'd10, 8'hF0, 16'h0, 8'h00, 8'h00);

        // Increment wrap, then write-over-increment priority on R3.
        cyc(1'b0, 1'b0, 4'd0, 8'h00, 16'hFFFF, 8'h08, 8'h00);
        cyc(1'b0, 1'b0, 4'd0, 8'h00, 16'h0000, 8'h00, 8'h08);
        cyc(1'b0, 1'b1, 4'd5, 8'h00, 16'h0000, 8'h00, 8'h00);
        cyc(1'b0, 1'b0, 4'd0, 8'h00, 16'h0010, 8'h08, 8'h08);
        cyc(1'b0, 1'b1, 4'd5, 8'h00, 16'h0000, 8'h00, 8'h00);

        // Same-cycle read and write of R2, then same-cycle read and increment.
        cyc(1'b0, 1'b0, 4'd0, 8'h00, 16'h1111, 8'h04, 8'h00);
        cyc(1'b0, 1'b1, 4'd4, 8'h00, 16'h2222, 8'h04, 8'h00);
        cyc(1'b0, 1'b1, 4'd4, 8'h00, 16'h0000, 8'h00, 8'h04);
        cyc(1'b0, 1'b1, 4'd4, 8'h00, 16'h0000, 8'h00, 8'h00);

        // Multi-register write.
        cyc(1'b0, 1'b0, 4'd0, 8'h00, 16'hBEEF, 8'hFF, 8'h00);
        for (int k = 0; k < NREGS; k++) cyc(1'b0, 1'b1, SEL_W'(k + 2), 8'h00, 16'h0, 8'h00, 8'h00);

        // Reset in the middle of a read/increment burst on R0.
        cyc(1'b0, 1'b0, 4'd0, 8'h00, 16'h0005, 8'h01, 8'h00);
        repeat (4) cyc(1'b0, 1'b1, 4'd2, 8'h00, 16'h0, 8'h00, 8'h01);
        cyc(1'b1, 1'b1, 4'd2, 8'h00, 16'h0, 8'h00, 8'h01);
        cyc(1'b0, 1'b1, 4'd2, 8'h00, 16'h0, 8'h00, 8'h00);
        cyc(1'b0, 1'b0, 4'd2, 8'h00, 16'h0, 8'h00, 8'h00);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [DATA_W-1:0] c;
            c = ($urandom_range(0, 7) == 0) ? 16'hFFFF : DATA_W'($urandom);
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 3) != 0),
                SEL_W'($urandom_range(0, 15)),
                EXT_W'($urandom),
                c,
                NREGS'($urandom & $urandom),
                NREGS'($urandom));
        end
        cyc(1'b0, 1'b0, 4'd0, 8'h00, 16'h0, 8'h00, 8'h00);

        drain = 0;
        while (q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #6;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/b_bus_regfile.md
# b_bus_regfile

Parametrised register file and registered B-bus source selector for the down-sampling datapath. It holds NREGS general data registers, each writable from the C bus, with optional per-register auto-increment for pointer/counter use. On request, it drives one source onto the B bus one cycle later, either a register or the zero-extended external memory byte. It generalises the fixed combinational B-bus selector in width, source count and timing, and adds write, increment and forwarding behaviour.

## Interface
Parameters:
- DATA_W, 16, width of registers, C bus and B bus
- NREGS, 8, number of internal registers (2..14)
- EXT_W, 8, width of external byte input; must be ≤ DATA_W
- SEL_W, $clog2(NREGS+2), width of read select (derived; do not override)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- rd_req  in  1  read request; sampled each rising edge
- rd_sel  in  SEL_W  source select: 0 = zero, 1 = ext_in, 2..NREGS+1 = R0..R(NREGS-1), others = zero
- ext_in  in  EXT_W  external memory byte, zero-extended on read
- c_bus  in  DATA_W  write data
- wr_en  in  NREGS  one-hot-or-more write mask; every set bit writes c_bus
- inc_en  in  NREGS  per-register increment enable
- b_bus  out  DATA_W  registered B-bus value
- b_valid  out  1  b_bus was loaded by a request in the previous cycle
- sel_err  out  1  registered; previous request used an out-of-range rd_sel

## Operation
- Reset: all Rk = 0, b_bus = 0, b_valid = 0, sel_err = 0. Reset overrides all other inputs in the same cycle, including mid-burst requests and writes.
- Register update per k, per edge, in priority order: wr_en[k] → Rk = c_bus; else inc_en[k] → Rk = Rk + 1 mod 2^DATA_W (wraps 0xFFFF→0x0000 for DATA_W=16); else hold.
- Read: when rd_req=1 at an edge, b_bus is loaded with the selected source, b_valid=1, sel_err=(rd_sel > NREGS+1). When rd_req=0, b_bus holds its last value and b_valid=0, sel_err=0.
- Out-of-range select loads zero and sets sel_err.
- ext_in is zero-extended: b_bus = {(DATA_W-EXT_W) zeros, ext_in}.
- Simultaneous read and update of the same register in one cycle: see Configuration.
- Writes to multiple registers in one cycle are legal and all take c_bus.

## Timing
- Read latency: 1 cycle. rd_req/rd_sel sampled at edge N; b_bus/b_valid valid after edge N, stable until edge N+1.
- Back-to-back requests are allowed every cycle; throughput is 1 read per cycle. No stall or backpressure.
- Write/increment latency: 1 cycle. Rk reflects the update after the edge.
- No combinational path from any input to any output.

## Configuration
- B_BUS_BYPASS_EN defined: a read of Rk in the same cycle as a write or increment of Rk returns the post-update value (c_bus, or Rk+1), so b_bus equals the new Rk.
- B_BUS_BYPASS_EN undefined: the same read returns the pre-update value (old Rk). No forwarding logic is present.

## Structure
- Shared package b_bus_pkg: select-code constants (SEL_ZERO=0, SEL_EXT=1, SEL_REG_BASE=2) and a function that maps a register index to its select code.
- One sub-module, b_bus_reg: a single DATA_W register with write-over-increment priority and synchronous reset. Instantiate it NREGS times with a generate loop.
- Top level contains the read mux, the optional bypass, and the output registers.

## Test plan
- Reset: drive garbage on all inputs with reset=1 for 2 cycles → b_bus=0, b_valid=0, sel_err=0; reading R0..R7 afterwards returns 0.
- Write/read: wr_en=8'h04, c_bus=16'hA5C3; next cycle rd_req=1, rd_sel=4 → b_bus=16'hA5C3, b_valid=1 one cycle later.
- Ext and zero: ext_in=8'hF0, rd_sel=1 → b_bus=16'h00F0; rd_sel=0 → 16'h0000; rd_sel=15 → 16'h0000 with sel_err=1.
- Increment wrap and priority: R3=16'hFFFF, inc_en[3]=1 → R3=16'h0000. Then wr_en[3]=1 and inc_en[3]=1 with c_bus=16'h0010 → R3=16'h0010.
- Same-cycle hazard: R2=16'h1111; wr_en[2]=1, c_bus=16'h2222, rd_sel=4, rd_req=1 → b_bus=16'h2222 with B_BUS_BYPASS_EN, 16'h1111 without.
- Reset mid-burst: rd_req=1 continuously reading R0=16'h0005 with inc_en[0]=1; assert reset for 1 cycle → next cycle b_bus=0, b_valid=0, R0=0; the first post-reset read returns 16'h0000.
